// File: rtl/stun_driver_pkg.sv
// Shared state codes and helpers for the stun driver and its consumers.
// health_status decodes the same S_* codes, so they must stay in sync.
// Holds the default stun timing and the counter width helper.
package stun_driver_pkg;

  typedef logic [3:0] state_code_t;

  localparam state_code_t S_IDLE      = 4'd0;
  localparam state_code_t S_HITSTUN   = 4'd9;
  localparam state_code_t S_BLOCKSTUN = 4'd10;

  localparam int HITSTUN_CYC_DEF   = 24;
  localparam int BLOCKSTUN_CYC_DEF = 12;
  localparam int RECOVER_CYC_DEF   = 8;

  // Largest of three timing values; sizes the shared stun/recover counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A movement FSM that happens to report a stun code outside a stun would
  // look like a fresh hit to health_status, so those codes collapse to idle.
  function automatic state_code_t sanitize_base(input state_code_t s);
    return ((s == S_HITSTUN) || (s == S_BLOCKSTUN)) ? S_IDLE : s;
  endfunction

endpackage

// File: rtl/stun_channel.sv
// One player's stun channel: IDLE -> HIT/BLK -> RECOVER -> IDLE.
// Registered output, one cycle after the hit/base sample; no retrigger during
// a stun or recovery, so each accepted hit yields exactly one entry edge.
module stun_channel
  import stun_driver_pkg::*;
#(
  parameter int HITSTUN_CYC   = HITSTUN_CYC_DEF,
  parameter int BLOCKSTUN_CYC = BLOCKSTUN_CYC_DEF,
  parameter int RECOVER_CYC   = RECOVER_CYC_DEF,
  parameter int CW            = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        base_state_i,
  input  logic              hit_i,
  input  logic              blocking_i,
  input  logic [2:0]        health_i,
  output logic [3:0]        state_o,
  output logic              stunned_o
);

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_HIT     = 2'd1,
    CH_BLK     = 2'd2,
    CH_RECOVER = 2'd3
  } ch_state_e;

  ch_state_e   fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_code_t out_q, out_d;
  logic        stun_q, stun_d;

  // Next-state, counter and output selection; output follows the next state
  // so the stun code appears on the cycle right after the accepted hit.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    case (fsm_q)
      CH_IDLE: begin
        if (hit_i && (health_i != 3'd0)) begin
          if (blocking_i) begin
            fsm_d = CH_BLK;
            cnt_d = CW'(BLOCKSTUN_CYC - 1);
          end else begin
            fsm_d = CH_HIT;
            cnt_d = CW'(HITSTUN_CYC - 1);
          end
        end
      end
      CH_HIT, CH_BLK: begin
        if (cnt_q == '0) begin
          fsm_d = CH_RECOVER;
          cnt_d = CW'(RECOVER_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CH_RECOVER: begin
        if (cnt_q == '0) begin
          fsm_d = CH_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        fsm_d = CH_IDLE;
        cnt_d = '0;
      end
    endcase

    case (fsm_d)
      CH_HIT:  out_d = S_HITSTUN;
      CH_BLK:  out_d = S_BLOCKSTUN;
      default: out_d = sanitize_base(base_state_i);
    endcase
    stun_d = (fsm_d == CH_HIT) || (fsm_d == CH_BLK);
  end

  // State, counter and output registers; reset aborts any running episode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q  <= CH_IDLE;
      cnt_q  <= '0;
      out_q  <= S_IDLE;
      stun_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      stun_q <= stun_d;
    end
  end

  assign state_o   = out_q;
  assign stunned_o = stun_q;

endmodule

// File: rtl/stun_driver.sv
// Drives both players' reported states with hit/block stun overrides.
// One-cycle registered latency from hit or base state to player state.
// No backpressure; hits arriving during a stun or recovery are dropped.
module stun_driver
  import stun_driver_pkg::*;
#(
  parameter int HITSTUN_CYC   = HITSTUN_CYC_DEF,
  parameter int BLOCKSTUN_CYC = BLOCKSTUN_CYC_DEF,
  parameter int RECOVER_CYC   = RECOVER_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] p1_base_state,
  input  logic [3:0] p2_base_state,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic       p1_blocking,
  input  logic       p2_blocking,
  input  logic [2:0] p1_health,
  input  logic [2:0] p2_health,
  output logic [3:0] player1_state,
  output logic [3:0] player2_state,
  output logic       p1_stunned,
  output logic       p2_stunned
);

  localparam int CW = $clog2(max3(HITSTUN_CYC, BLOCKSTUN_CYC, RECOVER_CYC) + 1);

  stun_channel #(
    .HITSTUN_CYC  (HITSTUN_CYC),
    .BLOCKSTUN_CYC(BLOCKSTUN_CYC),
    .RECOVER_CYC  (RECOVER_CYC),
    .CW           (CW)
  ) u_p1 (
    .clk_i       (clk),
    .rst_ni      (rst),
    .base_state_i(p1_base_state),
    .hit_i       (p1_hit),
    .blocking_i  (p1_blocking),
    .health_i    (p1_health),
    .state_o     (player1_state),
    .stunned_o   (p1_stunned)
  );

  stun_channel #(
    .HITSTUN_CYC  (HITSTUN_CYC),
    .BLOCKSTUN_CYC(BLOCKSTUN_CYC),
    .RECOVER_CYC  (RECOVER_CYC),
    .CW           (CW)
  ) u_p2 (
    .clk_i       (clk),
    .rst_ni      (rst),
    .base_state_i(p2_base_state),
    .hit_i       (p2_hit),
    .blocking_i  (p2_blocking),
    .health_i    (p2_health),
    .state_o     (player2_state),
    .stunned_o   (p2_stunned)
  );

endmodule
